// File: rtl/mux_2to1.sv
// mux_2to1: 2:1 data selector with a clocked capture copy and a saturating sel-toggle counter.
// Build macro MUX2TO1_REG_OUT_EN: when defined, out_q/valid_q are registered; otherwise out_q follows out.
module mux_2to1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] sel_toggles
);

  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic             sel_prev_r;
  logic [CNT_W-1:0] toggles_r;
  logic             toggle_s;

  // Data selection: only a definite 1 on sel picks in1, so X/Z on sel falls back to in0
  always_comb begin
    out = in0;
    if (sel == 1'b1) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

  assign toggle_s = (sel != sel_prev_r);

  // Select history and saturating transition count, sampled on every edge regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_prev_r <= 1'b0;
      toggles_r  <= '0;
    end else begin
      sel_prev_r <= sel;
      if (toggle_s && (toggles_r != CNT_MAX_C)) begin
        toggles_r <= toggles_r + CNT_W'(1'b1);
      end
    end
  end

  assign sel_toggles = toggles_r;

`ifdef MUX2TO1_REG_OUT_EN
  logic [WIDTH-1:0] out_q_r;
  logic             valid_q_r;

  // Capture the current selection when enabled; hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_r   <= '0;
      valid_q_r <= 1'b0;
    end else if (en) begin
      out_q_r   <= out;
      valid_q_r <= 1'b1;
    end
  end

  assign out_q   = out_q_r;
  assign valid_q = valid_q_r;
`else
  // Capture enable has no function without the output registers
  logic unused_en_s;
  assign unused_en_s = en;
  assign out_q       = out;
  assign valid_q     = 1'b1;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: randomized and directed stimulus against a behavioural model.
// Honours MUX2TO1_REG_OUT_EN the same way as the design (registered vs pass-through out_q).
`timescale 1ns/100ps
module tb_mux_2to1;

  localparam int WIDTH    = 8;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int CNT2_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in0, in1;
  logic             sel, en;
  logic [WIDTH-1:0] out, out_q;
  logic             valid_q;
  logic [CNT_W-1:0] sel_toggles;
  logic [WIDTH-1:0] out2, out_q2;
  logic             valid_q2;
  logic [1:0]       sel_toggles2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q;
  logic             m_valid;
  logic             m_prev;
  int               m_cnt;
  int               m_cnt2;

  mux_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel), .en(en),
    .out(out), .out_q(out_q), .valid_q(valid_q), .sel_toggles(sel_toggles)
  );

  mux_2to1 #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel), .en(en),
    .out(out2), .out_q(out_q2), .valid_q(valid_q2), .sel_toggles(sel_toggles2)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_mux(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic s);
    return (s === 1'b1) ? b : a;
  endfunction

  // Model of the clocked side-band, written from the behavioural rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      m_valid <= 1'b0;
      m_prev  <= 1'b0;
      m_cnt   <= 0;
      m_cnt2  <= 0;
    end else begin
      if (en === 1'b1) begin
        m_q     <= ref_mux(in0, in1, sel);
        m_valid <= 1'b1;
      end
      m_prev <= sel;
      if (sel !== m_prev) begin
        m_cnt  <= (m_cnt  < CNT_MAX)  ? m_cnt + 1  : m_cnt;
        m_cnt2 <= (m_cnt2 < CNT2_MAX) ? m_cnt2 + 1 : m_cnt2;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_q;
    logic             exp_v;
`ifdef MUX2TO1_REG_OUT_EN
    exp_q = m_q;
    exp_v = m_valid;
`else
    exp_q = ref_mux(in0, in1, sel);
    exp_v = 1'b1;
`endif
    check_eq({tag, ".out"},     32'(out),          32'(ref_mux(in0, in1, sel)));
    check_eq({tag, ".out_q"},   32'(out_q),        32'(exp_q));
    check_eq({tag, ".valid_q"}, 32'(valid_q),      32'(exp_v));
    check_eq({tag, ".cnt"},     32'(sel_toggles),  32'(m_cnt));
    check_eq({tag, ".cnt2"},    32'(sel_toggles2), 32'(m_cnt2));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;
    #2;
    check_all("reset");
    check_eq("reset.cnt0", 32'(sel_toggles), 32'd0);

    // Combinational selection, including unknown select, while still in reset
    @(negedge clk);
    in0 = 8'hAA; in1 = 8'h55; sel = 1'b0;
    #1 check_eq("comb.sel0", 32'(out), 32'h0000_00AA);
    sel = 1'b1;
    #1 check_eq("comb.sel1", 32'(out), 32'h0000_0055);
    sel = 1'bx;
    #1 check_eq("comb.selx", 32'(out), 32'(ref_mux(in0, in1, sel)));
    sel = 1'b0;
    #1 rst = 1'b0;

    // Single capture, then hold with en low
    @(negedge clk);
    en = 1'b1; sel = 1'b1; in0 = 8'h00; in1 = 8'h3C;
    #1 check_all("cap.before");
    @(posedge clk); #1;
    check_all("cap.after");
    check_eq("cap.cnt_first", 32'(sel_toggles), 32'd1);
    @(negedge clk);
    en = 1'b0; in0 = 8'h11; in1 = 8'h77;
    @(posedge clk); #1;
    check_all("cap.hold");

    // Fresh start, then six toggles: full count and saturation on the narrow counter
    @(negedge clk);
    rst = 1'b1; sel = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel = ~sel;
      @(posedge clk); #1;
      check_all("tog");
      if (i == 4) begin
        check_eq("tog.five", 32'(sel_toggles), 32'd5);
        check_eq("tog.sat5", 32'(sel_toggles2), 32'd3);
      end
    end
    check_eq("tog.six", 32'(sel_toggles), 32'd6);
    check_eq("tog.sat6", 32'(sel_toggles2), 32'd3);

    // Asynchronous reset between edges clears the side-band, out keeps following inputs
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_all("arst");
    check_eq("arst.cnt", 32'(sel_toggles), 32'd0);
    in0 = 8'hC3; in1 = 8'h5A; sel = 1'b1;
    #1 check_eq("arst.out", 32'(out), 32'h0000_005A);
    @(posedge clk); #1;
    check_all("arst.held");
    @(negedge clk);
    rst = 1'b0;

    // Randomized vectors, each held 5 ns, changes kept off the rising edge
    @(negedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      in0 = WIDTH'($urandom);
      in1 = WIDTH'($urandom);
      sel = 1'($urandom_range(1, 0));
      en  = 1'($urandom_range(1, 0));
      #2 check_all("rand");
      check_eq("rand.out", 32'(out), 32'(sel ? in1 : in0));
      #3;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
